// File: rtl/ex_pkg.sv
// Shared widths, opcode/funct constants and ALU control codes for the EX stage.
package ex_pkg;

  localparam int NB_ALU_OP   = 6;
  localparam int NB_ALU_CTRL = 4;
  localparam int NB_IMM      = 32;
  localparam int NB_PC       = 32;
  localparam int NB_DATA     = 32;
  localparam int NB_REG      = 5;
  localparam int NB_FCODE    = 6;

  localparam logic [NB_ALU_OP-1:0] OP_RTYPE   = 6'b000000;
  localparam logic [NB_ALU_OP-1:0] OP_BEQ     = 6'b000100;
  localparam logic [NB_ALU_OP-1:0] OP_BNE     = 6'b000101;
  localparam logic [NB_ALU_OP-1:0] OP_ADDI    = 6'b001000;
  localparam logic [NB_ALU_OP-1:0] OP_ADDIU   = 6'b001001;
  localparam logic [NB_ALU_OP-1:0] OP_SLTI    = 6'b001010;
  localparam logic [NB_ALU_OP-1:0] OP_SLTIU   = 6'b001011;
  localparam logic [NB_ALU_OP-1:0] OP_ANDI    = 6'b001100;
  localparam logic [NB_ALU_OP-1:0] OP_ORI     = 6'b001101;
  localparam logic [NB_ALU_OP-1:0] OP_XORI    = 6'b001110;
  localparam logic [NB_ALU_OP-1:0] OP_LUI     = 6'b001111;
  localparam logic [NB_ALU_OP-1:0] OP_LOAD_LO = 6'b100000;
  localparam logic [NB_ALU_OP-1:0] OP_LOAD_HI = 6'b100111;
  localparam logic [NB_ALU_OP-1:0] OP_SB      = 6'b101000;
  localparam logic [NB_ALU_OP-1:0] OP_SH      = 6'b101001;
  localparam logic [NB_ALU_OP-1:0] OP_SW      = 6'b101011;

  localparam logic [NB_FCODE-1:0] FN_SLL  = 6'b000000;
  localparam logic [NB_FCODE-1:0] FN_SRL  = 6'b000010;
  localparam logic [NB_FCODE-1:0] FN_SRA  = 6'b000011;
  localparam logic [NB_FCODE-1:0] FN_SLLV = 6'b000100;
  localparam logic [NB_FCODE-1:0] FN_SRLV = 6'b000110;
  localparam logic [NB_FCODE-1:0] FN_SRAV = 6'b000111;
  localparam logic [NB_FCODE-1:0] FN_ADD  = 6'b100000;
  localparam logic [NB_FCODE-1:0] FN_ADDU = 6'b100001;
  localparam logic [NB_FCODE-1:0] FN_SUB  = 6'b100010;
  localparam logic [NB_FCODE-1:0] FN_SUBU = 6'b100011;
  localparam logic [NB_FCODE-1:0] FN_AND  = 6'b100100;
  localparam logic [NB_FCODE-1:0] FN_OR   = 6'b100101;
  localparam logic [NB_FCODE-1:0] FN_XOR  = 6'b100110;
  localparam logic [NB_FCODE-1:0] FN_NOR  = 6'b100111;
  localparam logic [NB_FCODE-1:0] FN_SLT  = 6'b101010;
  localparam logic [NB_FCODE-1:0] FN_SLTU = 6'b101011;

  typedef enum logic [NB_ALU_CTRL-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_SLLV = 4'd11,
    ALU_SRLV = 4'd12,
    ALU_SRAV = 4'd13,
    ALU_LUI  = 4'd14,
    ALU_NONE = 4'd15
  } alu_ctrl_e;

endpackage

// File: rtl/ex_if.sv
// EX-stage bus: ID/EX inputs and EX/MEM outputs; master = upstream driver, slave = ex_stage.
interface ex_if;
  import ex_pkg::*;

  logic                 i_EX_reg_write;
  logic                 i_EX_mem_to_reg;
  logic                 i_EX_mem_read;
  logic                 i_EX_mem_write;
  logic                 i_EX_branch;
  logic                 i_EX_alu_src;
  logic                 i_EX_reg_dst;
  logic [NB_ALU_OP-1:0] i_EX_alu_op;
  logic [NB_PC-1:0]     i_EX_pc;
  logic [NB_DATA-1:0]   i_EX_data_a;
  logic [NB_DATA-1:0]   i_EX_data_b;
  logic [NB_IMM-1:0]    i_EX_immediate;
  logic [NB_REG-1:0]    i_EX_rt;
  logic [NB_REG-1:0]    i_EX_rd;

  logic                 o_EX_reg_write;
  logic                 o_EX_mem_to_reg;
  logic                 o_EX_mem_read;
  logic                 o_EX_mem_write;
  logic                 o_EX_branch;
  logic [NB_PC-1:0]     o_EX_branch_address;
  logic                 o_EX_zero;
  logic [NB_DATA-1:0]   o_EX_alu_result;
  logic [NB_DATA-1:0]   o_EX_data_a;
  logic [NB_REG-1:0]    o_EX_selected_reg;

  modport master (
    output i_EX_reg_write, i_EX_mem_to_reg, i_EX_mem_read, i_EX_mem_write, i_EX_branch,
           i_EX_alu_src, i_EX_reg_dst, i_EX_alu_op, i_EX_pc, i_EX_data_a, i_EX_data_b,
           i_EX_immediate, i_EX_rt, i_EX_rd,
    input  o_EX_reg_write, o_EX_mem_to_reg, o_EX_mem_read, o_EX_mem_write, o_EX_branch,
           o_EX_branch_address, o_EX_zero, o_EX_alu_result, o_EX_data_a, o_EX_selected_reg
  );

  modport slave (
    input  i_EX_reg_write, i_EX_mem_to_reg, i_EX_mem_read, i_EX_mem_write, i_EX_branch,
           i_EX_alu_src, i_EX_reg_dst, i_EX_alu_op, i_EX_pc, i_EX_data_a, i_EX_data_b,
           i_EX_immediate, i_EX_rt, i_EX_rd,
    output o_EX_reg_write, o_EX_mem_to_reg, o_EX_mem_read, o_EX_mem_write, o_EX_branch,
           o_EX_branch_address, o_EX_zero, o_EX_alu_result, o_EX_data_a, o_EX_selected_reg
  );

endinterface

// File: rtl/ex_alu.sv
// Combinational ALU: control code plus operands in, 32-bit result out (wraps mod 2^32).
module ex_alu
  import ex_pkg::*;
(
  input  alu_ctrl_e          ctrl_i,
  input  logic [NB_DATA-1:0] a_i,
  input  logic [NB_DATA-1:0] b_i,
  input  logic [4:0]         shamt_i,
  output logic [NB_DATA-1:0] result_o
);

  // Operation select
  always_comb begin
    result_o = 32'd0;
    case (ctrl_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_NOR:  result_o = ~(a_i | b_i);
      ALU_SLT:  result_o = {31'd0, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {31'd0, (a_i < b_i)};
      ALU_SLL:  result_o = b_i << shamt_i;
      ALU_SRL:  result_o = b_i >> shamt_i;
      ALU_SRA:  result_o = $signed(b_i) >>> shamt_i;
      ALU_SLLV: result_o = b_i << a_i[4:0];
      ALU_SRLV: result_o = b_i >> a_i[4:0];
      ALU_SRAV: result_o = $signed(b_i) >>> a_i[4:0];
      // lui takes the immediate through operand B and ignores A
      ALU_LUI:  result_o = {b_i[15:0], 16'h0000};
      default:  result_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Pipelined execute stage: ALU-control decode, operand/destination muxes, branch adder, EX/MEM register.
// Optional build macro EX_SHIFT_EN enables the six R-type shift functs (otherwise they decode as unknown).
module ex_stage
  import ex_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset_n,
  ex_if.slave  bus
);

  alu_ctrl_e          ctrl_s;
  logic [NB_DATA-1:0] op_b_s;
  logic [NB_DATA-1:0] result_s;
  logic [NB_FCODE-1:0] funct_s;

  logic [4:0]         flags_d, flags_q;
  logic [NB_PC-1:0]   branch_addr_d, branch_addr_q;
  logic               zero_d, zero_q;
  logic [NB_DATA-1:0] result_d, result_q;
  logic [NB_DATA-1:0] data_a_d, data_a_q;
  logic [NB_REG-1:0]  sel_reg_d, sel_reg_q;

  assign funct_s = bus.i_EX_immediate[5:0];

  // Opcode/funct to ALU-control decode
  always_comb begin
    ctrl_s = ALU_NONE;
    case (bus.i_EX_alu_op) inside
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD, FN_ADDU: ctrl_s = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl_s = ALU_SUB;
          FN_AND:          ctrl_s = ALU_AND;
          FN_OR:           ctrl_s = ALU_OR;
          FN_XOR:          ctrl_s = ALU_XOR;
          FN_NOR:          ctrl_s = ALU_NOR;
          FN_SLT:          ctrl_s = ALU_SLT;
          FN_SLTU:         ctrl_s = ALU_SLTU;
`ifdef EX_SHIFT_EN
          FN_SLL:          ctrl_s = ALU_SLL;
          FN_SRL:          ctrl_s = ALU_SRL;
          FN_SRA:          ctrl_s = ALU_SRA;
          FN_SLLV:         ctrl_s = ALU_SLLV;
          FN_SRLV:         ctrl_s = ALU_SRLV;
          FN_SRAV:         ctrl_s = ALU_SRAV;
`endif
          default:         ctrl_s = ALU_NONE;
        endcase
      end
      [OP_LOAD_LO:OP_LOAD_HI], OP_SB, OP_SH, OP_SW,
      OP_ADDI, OP_ADDIU: ctrl_s = ALU_ADD;
      OP_ANDI:           ctrl_s = ALU_AND;
      OP_ORI:            ctrl_s = ALU_OR;
      OP_XORI:           ctrl_s = ALU_XOR;
      OP_SLTI:           ctrl_s = ALU_SLT;
      OP_SLTIU:          ctrl_s = ALU_SLTU;
      OP_LUI:            ctrl_s = ALU_LUI;
      OP_BEQ, OP_BNE:    ctrl_s = ALU_SUB;
      default:           ctrl_s = ALU_NONE;
    endcase
  end

  assign op_b_s = bus.i_EX_alu_src ? bus.i_EX_immediate : bus.i_EX_data_b;

  ex_alu u_alu (
    .ctrl_i   (ctrl_s),
    .a_i      (bus.i_EX_data_a),
    .b_i      (op_b_s),
    .shamt_i  (bus.i_EX_immediate[10:6]),
    .result_o (result_s)
  );

  // Next-state values for the EX/MEM register
  always_comb begin
    flags_d       = {bus.i_EX_reg_write, bus.i_EX_mem_to_reg, bus.i_EX_mem_read,
                     bus.i_EX_mem_write, bus.i_EX_branch};
    branch_addr_d = bus.i_EX_pc + {bus.i_EX_immediate[29:0], 2'b00};
    result_d      = result_s;
    zero_d        = (result_s == 32'd0);
    data_a_d      = bus.i_EX_data_a;
    if (bus.i_EX_reg_dst) begin
      sel_reg_d = bus.i_EX_rd;
    end else begin
      sel_reg_d = bus.i_EX_rt;
    end
  end

  // EX/MEM pipeline register, cleared asynchronously by reset
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      flags_q       <= 5'd0;
      branch_addr_q <= 32'd0;
      zero_q        <= 1'b0;
      result_q      <= 32'd0;
      data_a_q      <= 32'd0;
      sel_reg_q     <= 5'd0;
    end else begin
      flags_q       <= flags_d;
      branch_addr_q <= branch_addr_d;
      zero_q        <= zero_d;
      result_q      <= result_d;
      data_a_q      <= data_a_d;
      sel_reg_q     <= sel_reg_d;
    end
  end

  assign bus.o_EX_reg_write      = flags_q[4];
  assign bus.o_EX_mem_to_reg     = flags_q[3];
  assign bus.o_EX_mem_read       = flags_q[2];
  assign bus.o_EX_mem_write      = flags_q[1];
  assign bus.o_EX_branch         = flags_q[0];
  assign bus.o_EX_branch_address = branch_addr_q;
  assign bus.o_EX_zero           = zero_q;
  assign bus.o_EX_alu_result     = result_q;
  assign bus.o_EX_data_a         = data_a_q;
  assign bus.o_EX_selected_reg   = sel_reg_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expectations from an independent reference model, compared one edge later.
module tb_ex_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ex_if u_if ();

  ex_stage u_dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (u_if)
  );

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic [31:0] br;
    logic [31:0] da;
    logic [4:0]  sel;
    logic [4:0]  flags;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] imm,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [5:0] fn;
    logic [4:0] sh;
    fn = imm[5:0];
    sh = imm[10:6];
    if (op == 6'd0) begin
      case (fn)
        6'h20, 6'h21: return a + b;
        6'h22, 6'h23: return a - b;
        6'h24: return a & b;
        6'h25: return a | b;
        6'h26: return a ^ b;
        6'h27: return ~(a | b);
        6'h2a: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h2b: return (a < b) ? 32'd1 : 32'd0;
`ifdef EX_SHIFT_EN
        6'h00: return b << sh;
        6'h02: return b >> sh;
        6'h03: return 32'($signed(b) >>> sh);
        6'h04: return b << a[4:0];
        6'h06: return b >> a[4:0];
        6'h07: return 32'($signed(b) >>> a[4:0]);
`endif
        default: return 32'd0;
      endcase
    end
    if ((op >= 6'h20 && op <= 6'h27) || op == 6'h28 || op == 6'h29 || op == 6'h2b ||
        op == 6'h08 || op == 6'h09) return a + b;
    case (op)
      6'h0c: return a & b;
      6'h0d: return a | b;
      6'h0e: return a ^ b;
      6'h0a: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h0b: return (a < b) ? 32'd1 : 32'd0;
      6'h0f: return {imm[15:0], 16'h0000};
      6'h04, 6'h05: return a - b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check("alu_result", u_if.o_EX_alu_result, e.res);
    check("zero", {31'd0, u_if.o_EX_zero}, {31'd0, e.zero});
    check("branch_address", u_if.o_EX_branch_address, e.br);
    check("data_a", u_if.o_EX_data_a, e.da);
    check("selected_reg", {27'd0, u_if.o_EX_selected_reg}, {27'd0, e.sel});
    check("flags", {27'd0, u_if.o_EX_reg_write, u_if.o_EX_mem_to_reg, u_if.o_EX_mem_read,
                    u_if.o_EX_mem_write, u_if.o_EX_branch}, {27'd0, e.flags});
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] a,
                       input logic [31:0] b, input logic src, input logic dst,
                       input logic [31:0] pc, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [4:0] flags);
    exp_t e;
    logic [31:0] bsel;
    @(negedge clk);
    u_if.i_EX_alu_op    = op;
    u_if.i_EX_immediate = imm;
    u_if.i_EX_data_a    = a;
    u_if.i_EX_data_b    = b;
    u_if.i_EX_alu_src   = src;
    u_if.i_EX_reg_dst   = dst;
    u_if.i_EX_pc        = pc;
    u_if.i_EX_rt        = rt;
    u_if.i_EX_rd        = rd;
    {u_if.i_EX_reg_write, u_if.i_EX_mem_to_reg, u_if.i_EX_mem_read,
     u_if.i_EX_mem_write, u_if.i_EX_branch} = flags;
    bsel    = src ? imm : b;
    e.res   = ref_alu(op, imm, a, bsel);
    e.zero  = (e.res == 32'd0);
    e.br    = pc + (imm << 2);
    e.da    = a;
    e.sel   = dst ? rd : rt;
    e.flags = flags;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_result"}, u_if.o_EX_alu_result, 32'd0);
    check({tag, "_branch"}, u_if.o_EX_branch_address, 32'd0);
    check({tag, "_data_a"}, u_if.o_EX_data_a, 32'd0);
    check({tag, "_misc"}, {20'd0, u_if.o_EX_zero, u_if.o_EX_selected_reg, u_if.o_EX_reg_write,
                           u_if.o_EX_mem_to_reg, u_if.o_EX_mem_read, u_if.o_EX_mem_write,
                           u_if.o_EX_branch}, 32'd0);
  endtask

  logic [5:0] op_tbl [12] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h09, 6'h0c, 6'h0a,
                              6'h0b, 6'h0f, 6'h05, 6'h3f};
  logic [5:0] fn_tbl [12] = '{6'h21, 6'h23, 6'h26, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03,
                              6'h04, 6'h07, 6'h25, 6'h3f};

  initial begin
    logic [31:0] r, imm;
    logic [5:0]  op;
    {u_if.i_EX_reg_write, u_if.i_EX_mem_to_reg, u_if.i_EX_mem_read,
     u_if.i_EX_mem_write, u_if.i_EX_branch} = 5'b11111;
    u_if.i_EX_alu_src = 1'b0; u_if.i_EX_reg_dst = 1'b1; u_if.i_EX_alu_op = 6'h00;
    u_if.i_EX_pc = 32'h1234; u_if.i_EX_data_a = 32'h55; u_if.i_EX_data_b = 32'h66;
    u_if.i_EX_immediate = 32'h20; u_if.i_EX_rt = 5'd3; u_if.i_EX_rd = 5'd9;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    drive(6'h00, 32'h0000_0020, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 32'h0, 5'd1, 5'd2, 5'b10000);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(6'h00, 32'h0000_0022, 32'd5, 32'd5, 1'b0, 1'b1, 32'h4, 5'd1, 5'd8, 5'b10000);
    drive(6'h00, 32'h0000_0027, 32'd0, 32'd0, 1'b0, 1'b1, 32'h8, 5'd1, 5'd8, 5'b10000);
    drive(6'h23, 32'hFFFF_FFFC, 32'h100, 32'h77, 1'b1, 1'b0, 32'hC, 5'd7, 5'd12, 5'b11100);
    drive(6'h04, 32'hFFFF_FFFF, 32'hABCD, 32'hABCD, 1'b0, 1'b0, 32'h40, 5'd4, 5'd5, 5'b00001);
    drive(6'h00, 32'h0000_0103, 32'd0, 32'h8000_0000, 1'b0, 1'b1, 32'h44, 5'd4, 5'd5, 5'b10000);
    drive(6'h0f, 32'h0000_BEEF, 32'h1111, 32'h0, 1'b1, 1'b0, 32'h48, 5'd6, 5'd5, 5'b10000);
    drive(6'h0a, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 1'b1, 1'b0, 32'h4C, 5'd6, 5'd5, 5'b10000);
    drive(6'h0b, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 1'b1, 1'b0, 32'h50, 5'd6, 5'd5, 5'b10000);
    drive(6'h3e, 32'h0000_0001, 32'h7, 32'h9, 1'b1, 1'b0, 32'h54, 5'd6, 5'd5, 5'b00000);
    drive(6'h00, 32'h0000_0001, 32'h7, 32'h9, 1'b0, 1'b1, 32'hFFFF_FFF0, 5'd6, 5'd31, 5'b00000);
    drive(6'h00, 32'h0000_0000, 32'h7, 32'h1234_5678, 1'b0, 1'b1, 32'h58, 5'd6, 5'd31, 5'b10000);

    // Randomised vectors
    for (int i = 0; i < 40; i++) begin
      r  = $urandom();
      op = op_tbl[$urandom_range(0, 11)];
      if (op == 6'h00) imm = {r[31:11], 5'($urandom_range(0, 31)), fn_tbl[$urandom_range(0, 11)]};
      else imm = r;
      drive(op, imm, $urandom(), $urandom(), (op == 6'h0f) ? 1'b1 : 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom(), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    check("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
